i2c_cfg_sequencer: RTL and testbench



---
 rtl/i2c_cfg_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a register-configuration table and issues one I2C
// driver transaction per entry, with optional read-back verify, bounded retry
// on NACK or mismatch, delay entries and a busy-handshake timeout.
module i2c_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR  = 7'h3C,
    parameter int         TBL_AW    = 8,
    parameter int         MAX_RETRY = 3,
    parameter int         DLY_UNIT  = 800,
    parameter int         BUSY_TO   = 64,
    parameter int         VERIFY    = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_fail,
    output logic [TBL_AW-1:0] fail_index,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              start_en,
    output logic              wr_rd_flag,
    output logic [7:0]        i2c_device_addr,
    output logic [15:0]       register,
    output logic [7:0]        data_byte,
    input  logic              busy,
    input  logic              err,
    input  logic [7:0]        rd_data
);

    localparam int RET_W = $clog2(MAX_RETRY + 2);
    localparam int TO_W  = $clog2(BUSY_TO + 1);
    localparam logic [15:0]       REG_END  = 16'hFFFF;
    localparam logic [15:0]       REG_DLY  = 16'hFFFE;
    localparam logic [TBL_AW-1:0] IDX_LAST = {TBL_AW{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_XFER,
        S_CHECK,
        S_DELAY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_q;
    logic [TBL_AW-1:0] idx_q;
    logic [TBL_AW-1:0] tbl_addr_q;
    logic [RET_W-1:0]  retry_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [23:0]       dly_q;
    logic [15:0]       reg_q;
    logic [7:0]        data_q;
    logic              err_q;
    logic              verify_ph_q;
    logic              wr_rd_q;
    logic              start_en_q;
    logic              init_busy_q;
    logic              init_done_q;
    logic              init_fail_q;
    logic [TBL_AW-1:0] fail_index_q;
    logic [7:0]        dev_addr_q;

    logic [TBL_AW-1:0] idx_next_d;
    logic              idx_last_d;
    logic              retry_ok_d;
    logic              rd_match_d;
    logic              to_expired_d;
    logic [23:0]       dly_load_d;

    // Helper terms shared by several FSM branches (advance, retry, timeout).
    always_comb begin
        idx_next_d   = idx_q + 1'b1;
        idx_last_d   = (idx_q == IDX_LAST);
        retry_ok_d   = (retry_q < RET_W'(MAX_RETRY));
        rd_match_d   = (rd_data == data_q);
        to_expired_d = (to_cnt_q == TO_W'(BUSY_TO - 1));
        dly_load_d   = 24'(tbl_data[7:0]) * 24'(DLY_UNIT);
    end

    // Sequencer FSM; every output is a register so the driver sees clean levels.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tbl_addr_q   <= '0;
            retry_q      <= '0;
            to_cnt_q     <= '0;
            dly_q        <= '0;
            reg_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            verify_ph_q  <= 1'b0;
            wr_rd_q      <= 1'b0;
            start_en_q   <= 1'b0;
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            init_fail_q  <= 1'b0;
            fail_index_q <= '0;
            dev_addr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init_start) begin
                        init_done_q <= 1'b0;
                        init_fail_q <= 1'b0;
                        init_busy_q <= 1'b1;
                        idx_q       <= '0;
                        tbl_addr_q  <= '0;
                        dev_addr_q  <= {1'b0, DEV_ADDR};
                        state_q     <= S_FETCH;
                    end
                end

                // ROM is registered: address was set on entry, data arrives next cycle.
                S_FETCH: state_q <= S_LATCH;

                S_LATCH: begin
                    reg_q   <= tbl_data[23:8];
                    data_q  <= tbl_data[7:0];
                    retry_q <= '0;
                    if (tbl_data[23:8] == REG_END) begin
                        init_done_q <= 1'b1;
                        init_busy_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (tbl_data[23:8] == REG_DLY) begin
                        if (tbl_data[7:0] == 8'd0) begin
                            if (idx_last_d) begin
                                init_done_q <= 1'b1;
                                init_busy_q <= 1'b0;
                                state_q     <= S_DONE;
                            end else begin
                                idx_q      <= idx_next_d;
                                tbl_addr_q <= idx_next_d;
                                state_q    <= S_FETCH;
                            end
                        end else begin
                            dly_q   <= dly_load_d;
                            state_q <= S_DELAY;
                        end
                    end else begin
                        wr_rd_q     <= 1'b0;
                        verify_ph_q <= 1'b0;
                        err_q       <= 1'b0;
                        start_en_q  <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= S_ISSUE;
                    end
                end

                // start_en drops on the same edge that first sees busy, so the
                // driver can never re-trigger when it returns to idle.
                S_ISSUE: begin
                    if (busy) begin
                        start_en_q <= 1'b0;
                        err_q      <= err_q | err;
                        state_q    <= S_XFER;
                    end else if (to_expired_d) begin
                        start_en_q   <= 1'b0;
                        init_fail_q  <= 1'b1;
                        fail_index_q <= idx_q;
                        init_busy_q  <= 1'b0;
                        state_q      <= S_FAIL;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                // err is only meaningful while busy, so it is made sticky here.
                S_XFER: begin
                    if (busy) begin
                        err_q <= err_q | err;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (err_q || (verify_ph_q && !rd_match_d)) begin
                        if (retry_ok_d) begin
                            retry_q     <= retry_q + 1'b1;
                            err_q       <= 1'b0;
                            verify_ph_q <= 1'b0;
                            wr_rd_q     <= 1'b0;
                            start_en_q  <= 1'b1;
                            to_cnt_q    <= '0;
                            state_q     <= S_ISSUE;
                        end else begin
                            init_fail_q  <= 1'b1;
                            fail_index_q <= idx_q;
                            init_busy_q  <= 1'b0;
                            state_q      <= S_FAIL;
                        end
                    end else if (!verify_ph_q && (VERIFY != 0)) begin
                        err_q       <= 1'b0;
                        verify_ph_q <= 1'b1;
                        wr_rd_q     <= 1'b1;
                        start_en_q  <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= S_ISSUE;
                    end else if (idx_last_d) begin
                        init_done_q <= 1'b1;
                        init_busy_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q      <= idx_next_d;
                        tbl_addr_q <= idx_next_d;
                        state_q    <= S_FETCH;
                    end
                end

                S_DELAY: begin
                    if (dly_q != 24'd0) begin
                        dly_q <= dly_q - 24'd1;
                    end else if (idx_last_d) begin
                        init_done_q <= 1'b1;
                        init_busy_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q      <= idx_next_d;
                        tbl_addr_q <= idx_next_d;
                        state_q    <= S_FETCH;
                    end
                end

                // Status was set on entry; one dead cycle swallows a coincident init_start.
                S_DONE: state_q <= S_IDLE;
                S_FAIL: state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign init_busy       = init_busy_q;
    assign init_done       = init_done_q;
    assign init_fail       = init_fail_q;
    assign fail_index      = fail_index_q;
    assign tbl_addr        = tbl_addr_q;
    assign start_en        = start_en_q;
    assign wr_rd_flag      = wr_rd_q;
    assign i2c_device_addr = dev_addr_q;
    assign register        = reg_q;
    assign data_byte       = data_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Testbench for i2c_cfg_sequencer: table ROM and I2C driver models, a
// table-walk reference model feeding a scoreboard, and a decoupled monitor.
module tb_i2c_cfg_sequencer;

  localparam int         AW   = 4;
  localparam int         NENT = 16;
  localparam int         MAXR = 3;
  localparam int         DLYU = 10;
  localparam int         BTO  = 64;
  localparam logic [6:0] DEVA = 7'h3C;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy, init_done, init_fail;
  logic [AW-1:0] fail_index, tbl_addr;
  logic [23:0]   tbl_data;
  logic          start_en, wr_rd_flag;
  logic [7:0]    i2c_device_addr;
  logic [15:0]   register;
  logic [7:0]    data_byte;
  logic          busy, err;
  logic [7:0]    rd_data;

  always #5 clk_i = ~clk_i;

  i2c_cfg_sequencer #(
    .DEV_ADDR (DEVA),
    .TBL_AW   (AW),
    .MAX_RETRY(MAXR),
    .DLY_UNIT (DLYU),
    .BUSY_TO  (BTO),
    .VERIFY   (1)
  ) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .init_fail      (init_fail),
    .fail_index     (fail_index),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .start_en       (start_en),
    .wr_rd_flag     (wr_rd_flag),
    .i2c_device_addr(i2c_device_addr),
    .register       (register),
    .data_byte      (data_byte),
    .busy           (busy),
    .err            (err),
    .rd_data        (rd_data)
  );

  typedef struct packed {
    logic nack;
    logic corrupt;
  } resp_t;

  resp_t       script[$];
  logic [23:0] rom [NENT];
  logic [24:0] exp_tx[$];
  logic [5:0]  exp_out[$];
  logic [7:0]  mem [65536];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          dead   = 1'b0;

  // Synchronous table ROM.
  always @(posedge clk_i) tbl_data <= rom[tbl_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic resp_t resp_at(input int k);
    if (k < script.size()) return script[k];
    return '0;
  endfunction

  // Reference model: walk the table and the response script entry by entry.
  task automatic build_expect();
    int          si;
    bit          ok;
    logic [15:0] rg;
    logic [7:0]  dt;
    resp_t       rw, rr;
    si = 0;
    exp_tx.delete();
    exp_out.delete();
    for (int i = 0; i < NENT; i++) begin
      rg = rom[i][23:8];
      dt = rom[i][7:0];
      if (rg == 16'hFFFF) begin
        exp_out.push_back({2'b10, 4'h0});
        return;
      end
      if (rg != 16'hFFFE) begin
        ok = 1'b0;
        for (int a = 0; a <= MAXR && !ok; a++) begin
          exp_tx.push_back({1'b0, rg, dt});
          rw = resp_at(si);
          si++;
          if (!rw.nack) begin
            exp_tx.push_back({1'b1, rg, dt});
            rr = resp_at(si);
            si++;
            ok = !rr.nack && !rr.corrupt;
          end
        end
        if (!ok) begin
          exp_out.push_back({2'b01, 4'(i)});
          return;
        end
      end
    end
    exp_out.push_back({2'b10, 4'h0});
  endtask

  // I2C driver model: responds to start_en, consumes one script entry per transaction.
  initial begin : driver
    int          st, wait_c, len;
    resp_t       r;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd;
    busy = 1'b0; err = 1'b0; rd_data = 8'h00;
    st = 0; wait_c = 0; len = 0; r = '0; a = '0; d = '0; rd = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_n) begin
        busy = 1'b0; err = 1'b0; st = 0;
      end else begin
        case (st)
          0: if (start_en && !dead) begin
               wait_c = $urandom_range(0, 3);
               st = 1;
             end
          1: if (wait_c == 0) begin
               a = register; d = data_byte; rd = wr_rd_flag;
               if (script.size() > 0) r = script.pop_front();
               else r = '0;
               busy = 1'b1;
               err  = r.nack;
               len  = $urandom_range(1, 4);
               st   = 2;
             end else begin
               wait_c--;
             end
          default: if (len == 0) begin
               busy = 1'b0;
               err  = 1'b0;
               if (!r.nack) begin
                 if (!rd) mem[a] = d;
                 else rd_data = mem[a] ^ (r.corrupt ? 8'h03 : 8'h00);
               end
               st = 0;
             end else begin
               len--;
             end
        endcase
      end
    end
  end

  // Monitor: compares transactions and walk outcomes against the scoreboard.
  initial begin : monitor
    bit          in_tx, pd, pf;
    int          both;
    logic [24:0] hold, e;
    logic [5:0]  eo, ao;
    in_tx = 0; pd = 0; pf = 0; both = 0; hold = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        in_tx = 0; pd = 0; pf = 0; both = 0;
      end else begin
        if (start_en && busy && !in_tx) begin
          in_tx = 1;
          hold = {wr_rd_flag, register, data_byte};
          if (exp_tx.size() == 0) begin
            n_chk++;
            $display("FAIL tx_unexpected: got 0x%0h, expected no transaction", hold);
          end else begin
            e = exp_tx.pop_front();
            check("tx", hold, e);
          end
          check("dev_addr", i2c_device_addr, {1'b0, DEVA});
        end
        if (in_tx && !busy) begin
          in_tx = 0;
          check("tx_hold", {wr_rd_flag, register, data_byte}, hold);
        end
        if (start_en && busy) both++;
        else both = 0;
        if (both == 2) begin
          n_chk++;
          $display("FAIL start_en_after_busy: got start_en=1 a cycle after busy, expected 0");
        end
        if ((init_done && !pd) || (init_fail && !pf)) begin
          ao = {init_done, init_fail, (init_fail ? fail_index : 4'h0)};
          if (exp_out.size() == 0) begin
            n_chk++;
            $display("FAIL outcome_unexpected: got 0x%0h, expected none", ao);
          end else begin
            eo = exp_out.pop_front();
            check("outcome", ao, eo);
          end
          check("outcome_busy_low", init_busy, 0);
        end
        pd = init_done;
        pf = init_fail;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk_i); #1 init_start = 1'b1;
    @(posedge clk_i); #1 init_start = 1'b0;
  endtask

  task automatic run_walk(input string name, input bit extra_start, output int cyc);
    cyc = 0;
    pulse_start();
    check({name, "_busy_set"}, {init_busy, init_done, init_fail}, 3'b100);
    if (extra_start) begin
      repeat (3) @(posedge clk_i);
      pulse_start();
    end
    while (init_busy && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
    end
    if (init_busy) begin
      n_chk++;
      $display("FAIL %s_timeout: got init_busy=1 after %0d cycles, expected 0", name, cyc);
    end
    repeat (3) @(negedge clk_i);
    check({name, "_tx_left"}, exp_tx.size(), 0);
    check({name, "_out_left"}, exp_out.size(), 0);
    exp_tx.delete();
    exp_out.delete();
  endtask

  task automatic fill_rom(input logic [23:0] e0, input logic [23:0] e1);
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
    rom[0] = e0;
    rom[1] = e1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_status"}, {init_busy, init_done, init_fail, fail_index}, 0);
    check({name, "_tbl_addr"}, tbl_addr, 0);
    check({name, "_drv_ctl"}, {start_en, wr_rd_flag, i2c_device_addr}, 0);
    check({name, "_drv_data"}, {register, data_byte}, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int    cyc, hi, k;
    resp_t rr;
    for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single write + verify with a spurious init_start while busy.
    fill_rom(24'h123456, 24'hFFFF00);
    script.delete();
    build_expect();
    run_walk("basic", 1'b1, cyc);
    repeat (4) @(negedge clk_i);
    check("basic_done_sticky", {init_done, init_fail}, 2'b10);

    // Every attempt NACKed: four writes, then fail at index 0.
    script.delete();
    for (int i = 0; i < 10; i++) script.push_back('{nack: 1'b1, corrupt: 1'b0});
    build_expect();
    run_walk("nack", 1'b0, cyc);
    check("nack_fail_sticky", {init_done, init_fail, fail_index}, {2'b01, 4'h0});

    // Delay entry of 2 ticks, no transactions.
    fill_rom(24'hFFFE02, 24'hFFFF00);
    script.delete();
    build_expect();
    run_walk("delay", 1'b0, cyc);
    check_range("delay_cycles", cyc, 2 * DLYU, 2 * DLYU + 8);
    check("delay_done", {init_done, init_fail}, 2'b10);

    // Driver never answers: busy timeout.
    fill_rom(24'h123456, 24'hFFFF00);
    dead = 1'b1;
    exp_tx.delete();
    exp_out.delete();
    exp_out.push_back({2'b01, 4'h0});
    pulse_start();
    k = 0;
    while (!start_en && k < 10) begin
      @(negedge clk_i);
      k++;
    end
    check("timeout_start_seen", start_en, 1);
    cyc = 0; hi = 0;
    while (!init_fail && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (start_en) hi++;
    end
    check_range("timeout_cycles", cyc, BTO - 1, BTO + 1);
    check("timeout_start_held", hi, cyc - 1);
    repeat (2) @(negedge clk_i);
    check("timeout_after", {start_en, init_busy, init_fail, fail_index}, {3'b001, 4'h0});
    check("timeout_out_left", exp_out.size(), 0);
    dead = 1'b0;
    exp_out.delete();

    // Read-back mismatch once (0x55 for 0x56), then success.
    fill_rom(24'h123456, 24'hFFFF00);
    script.delete();
    script.push_back('{nack: 1'b0, corrupt: 1'b0});
    script.push_back('{nack: 1'b0, corrupt: 1'b1});
    build_expect();
    run_walk("verify_retry", 1'b0, cyc);
    check("verify_retry_done", {init_done, init_fail}, 2'b10);

    // Full table with no end marker: stop at the last index, no wrap.
    for (int i = 0; i < NENT; i++) rom[i] = {16'(16'h0100 + i), 8'($urandom)};
    script.delete();
    build_expect();
    run_walk("no_wrap", 1'b0, cyc);
    check("no_wrap_done", {init_done, init_fail}, 2'b10);

    // Randomized tables and driver responses.
    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(1, NENT - 1);
      for (int i = 0; i < NENT; i++) rom[i] = 24'hFFFF00;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) rom[i] = {16'hFFFE, 8'($urandom_range(0, 3))};
        else rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom)};
      end
      script.delete();
      for (int i = 0; i < 150; i++) begin
        rr.nack    = ($urandom_range(0, 5) == 0);
        rr.corrupt = ($urandom_range(0, 5) == 0);
        script.push_back(rr);
      end
      build_expect();
      run_walk("random", 1'b0, cyc);
    end

    // Reset asserted mid-transfer.
    fill_rom(24'hABCD11, 24'hFFFF00);
    script.delete();
    build_expect();
    pulse_start();
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("rst_xfer_busy_seen", busy, 1);
    @(posedge clk_i);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_xfer");
    exp_tx.delete();
    exp_out.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_xfer_idle", {init_busy, start_en, busy}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
